reg16_write_arbiter: RTL and testbench
======================================

Name: reg16_write_arbiter

Overview:
- Round-robin arbiter that shares one 16-bit storage register among N_REQ writers.
- Each writer raises a request with its data. The arbiter selects one winner, performs the register load, then returns a one-cycle acknowledge to that writer.
- Sits between CPU-side producers (ALU result path, I/O latch, debug port) and a shared 16-bit register. Every requester can read the register output at all times.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, data width of the shared register.
- IDW, $clog2(N_REQ), width of the grant index; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- req  input  N_REQ  per-requester write request, level, held until ack.
- data_in  input  N_REQ*WIDTH  flattened write data; requester k uses bits [k*WIDTH +: WIDTH].
- ack  output  N_REQ  one-hot, one-cycle pulse: write for requester k is complete.
- grant_id  output  IDW  index of the current or last winner.
- busy  output  1  high while a transaction is in progress (state not IDLE).
- reg_out  output  WIDTH  current contents of the shared register.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - While rst_n=0 at an edge: state=IDLE, reg_out=0, ack=0, grant_id=0, busy=0, priority pointer ptr=0.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If any req bit is set, choose the winner by round-robin: the first set bit scanning ptr, ptr+1, ... mod N_REQ.
  - Latch the winner into grant_id and move to WRITE.
  - If no req bit is set, stay in IDLE.
- WRITE:
  - Internal load=1.
  - The register captures data_in[grant_id] at the end of this cycle; move to ACK.
- ACK:
  - ack[grant_id]=1 for exactly this cycle; reg_out already shows the new value.
  - ptr <= (grant_id+1) mod N_REQ; move to IDLE.
- busy = (state != IDLE).
- Latency and throughput:
  - req seen in IDLE -> register updated 2 edges later -> ack visible in the cycle after the update.
  - Minimum 3 cycles per write; at most one write per 3 cycles.
- Requester rules:
  - data_in[k] must be stable from the cycle req[k] is sampled through the WRITE cycle.
  - The requester drops req[k] in the cycle after it sees ack[k].
  - If req[k] is still high in the following IDLE cycle, it is treated as a new request.
- Request withdrawn after grant: the transaction still completes and the ack still pulses. No cancellation.
- New requests arriving during WRITE/ACK are ignored until IDLE; nothing is lost because req is level.
- Fairness: the winner becomes lowest priority next round. With all req held high, the grant order is 0,1,2,...,N_REQ-1,0,...
- Wrap-around: ptr increments modulo N_REQ, and for non-power-of-2 N_REQ it never holds an index >= N_REQ.
- Reset mid-transaction: reset aborts the transaction. No ack is issued, and reg_out=0 even if the WRITE edge coincides with reset (reset wins).
- ack is never asserted for more than one bit or more than one cycle per transaction.
- reg_out changes only on the edge that ends a WRITE cycle, or on reset.

Decomposition:
- Shared package/include:
  - FSM state encoding constants (ST_IDLE=2'd0, ST_WRITE=2'd1, ST_ACK=2'd2).
  - Default N_REQ and WIDTH constants.
- One sub-module, reg16_sync: a WIDTH-bit load-enable register with synchronous active-low clear.
  - Ports: out, in, load, clk, rst_n.
  - The arbiter drives it with data_in[grant_id] and load=(state==WRITE).
- Round-robin selection is combinational logic inside the arbiter; it is not a separate module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> reg_out=0, ack=0, busy=0 throughout; first grant after release is 0.
- Single write: req=4'b0100 with data_in[2]=16'hBEEF in IDLE -> grant_id=2, busy=1; reg_out=16'hBEEF 2 edges later; ack=4'b0100 for exactly 1 cycle.
- Round-robin: req=4'b1111 held, data_in[k]=16'h1000+k -> ack sequence 0,1,2,3,0 spaced 3 cycles apart; reg_out follows 16'h1000, 16'h1001, 16'h1002, 16'h1003.
- Priority rotation: after a grant to requester 3, set req=4'b0011 -> next grant 0, then 1; requester 1 is not starved when req[0] is held high.
- Withdrawn request: req[1] raised, then dropped during WRITE with data_in[1]=16'h00FF -> write completes, reg_out=16'h00FF, ack[1] still pulses.
- Reset mid-op: assert rst_n=0 on the WRITE cycle with data 16'h1234 -> reg_out=0, no ack, state IDLE, ptr=0.

Source files
------------

// File: rtl/reg16_write_arbiter_pkg.sv
// Shared constants for the round-robin register write arbiter.
// FSM encoding and default sizing.
package reg16_write_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/reg16_write_arbiter_if.sv
// Requester-side bundle of the shared register arbiter.
// master = requesters, slave = arbiter.
interface reg16_write_arbiter_if
    import reg16_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) ();

    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       ack;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic [WIDTH-1:0]       reg_out;

    modport master (
        output req, data_in,
        input  ack, grant_id, busy, reg_out
    );

    modport slave (
        input  req, data_in,
        output ack, grant_id, busy, reg_out
    );

endinterface

// File: rtl/reg16_sync.sv
// Load-enable register with synchronous active-low clear.
// Clear has priority over load.
module reg16_sync #(
    parameter int WIDTH = 16
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             clk,
    input  logic             rst_n
);

    // Clear wins over a coincident load.
    always_ff @(posedge clk) begin
        if (!rst_n)
            out <= '0;
        else if (load)
            out <= in;
    end

endmodule

// File: rtl/reg16_write_arbiter.sv
// Round-robin arbiter sharing one register among N_REQ writers.
// Each write takes IDLE -> WRITE -> ACK, three cycles minimum.
module reg16_write_arbiter
    import reg16_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg16_write_arbiter_if.slave bus
);

    localparam int IDW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   rr_win;
    logic             found;
    int               k;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] reg_q;
    logic             load;

    // State, winner and priority pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // First set request scanning upward from ptr, wrapping at N_REQ.
    always_comb begin
        rr_win = ptr_q;
        found  = 1'b0;
        k      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr_q) + i) % N_REQ;
            if (!found && bus.req[IDW'(k)]) begin
                found  = 1'b1;
                rr_win = IDW'(k);
            end
        end
    end

    // Next state; winner becomes lowest priority once acked.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d = rr_win;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_ACK;
            ST_ACK: begin
                ptr_d   = (grant_q == IDW'(N_REQ - 1)) ?
                          '0 : grant_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-hot ack for the winner during the ACK cycle only.
    always_comb begin
        bus.ack = '0;
        if (state_q == ST_ACK)
            bus.ack[grant_q] = 1'b1;
    end

    assign load    = (state_q == ST_WRITE);
    assign wr_data = bus.data_in[int'(grant_q)*WIDTH +: WIDTH];

    reg16_sync #(.WIDTH(WIDTH)) u_reg (
        .out   (reg_q),
        .in    (wr_data),
        .load  (load),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign bus.reg_out  = reg_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Directed bench for reg16_write_arbiter.
// Samples 1ns after each rising edge.
module tb_reg16_write_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reg16_write_arbiter_if #(.N_REQ(4), .WIDTH(16)) bus ();

    reg16_write_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++)
            bus.data_in[k*16 +: 16] = 16'hA000 + 16'(k);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (bus.reg_out !== 16'h0 || bus.ack !== 4'b0 ||
                bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold reg=%h ack=%b busy=%b want 0000/0000/0",
                         bus.reg_out, bus.ack, bus.busy);
            end
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant id=%0d busy=%b want 0/1",
                     bus.grant_id, bus.busy);
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.ack !== 4'b0001 || bus.reg_out !== 16'hA000) begin
            bad++;
            $display("FAIL reset_first_ack ack=%b reg=%h want 0001/a000",
                     bus.ack, bus.reg_out);
        end
        tick();
        total++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_done ack=%b busy=%b want 0000/0",
                     bus.ack, bus.busy);
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        bus.data_in[2*16 +: 16] = 16'hBEEF;
        tick();
        total++;
        if (bus.grant_id !== 2'd2 || bus.busy !== 1'b1 ||
            bus.reg_out !== 16'hA000 || bus.ack !== 4'b0) begin
            bad++;
            $display("FAIL single_grant id=%0d busy=%b reg=%h ack=%b want 2/1/a000/0000",
                     bus.grant_id, bus.busy, bus.reg_out, bus.ack);
        end
        tick();
        total++;
        if (bus.reg_out !== 16'hBEEF || bus.ack !== 4'b0100) begin
            bad++;
            $display("FAIL single_ack reg=%h ack=%b want beef/0100",
                     bus.reg_out, bus.ack);
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0 ||
            bus.reg_out !== 16'hBEEF) begin
            bad++;
            $display("FAIL single_done ack=%b busy=%b reg=%h want 0000/0/beef",
                     bus.ack, bus.busy, bus.reg_out);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_id;
        logic [3:0]  exp_ack;
        logic [15:0] exp_reg;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            bus.data_in[k*16 +: 16] = 16'h1000 + 16'(k);
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_id  = 2'(n % 4);
            exp_ack = 4'b0001 << exp_id;
            exp_reg = 16'h1000 + 16'(exp_id);
            tick();
            total++;
            if (bus.grant_id !== exp_id || bus.ack !== 4'b0) begin
                bad++;
                $display("FAIL rr_grant n=%0d id=%0d ack=%b want %0d/0000",
                         n, bus.grant_id, bus.ack, exp_id);
            end
            tick();
            total++;
            if (bus.ack !== exp_ack || bus.reg_out !== exp_reg) begin
                bad++;
                $display("FAIL rr_ack n=%0d ack=%b reg=%h want %b/%h",
                         n, bus.ack, bus.reg_out, exp_ack, exp_reg);
            end
            tick();
            total++;
            if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_gap n=%0d ack=%b busy=%b want 0000/0",
                         n, bus.ack, bus.busy);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_priority();
        logic [1:0] exp_id;
        bus.req = 4'b1000;
        tick();
        total++;
        if (bus.grant_id !== 2'd3) begin
            bad++;
            $display("FAIL prio_g3 id=%0d want 3", bus.grant_id);
        end
        bus.req = 4'b0000;
        tick();
        tick();
        bus.req = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            exp_id = 2'(n % 2);
            tick();
            total++;
            if (bus.grant_id !== exp_id) begin
                bad++;
                $display("FAIL prio_grant n=%0d id=%0d want %0d",
                         n, bus.grant_id, exp_id);
            end
            tick();
            total++;
            if (bus.ack !== (4'b0001 << exp_id)) begin
                bad++;
                $display("FAIL prio_ack n=%0d ack=%b want %b",
                         n, bus.ack, 4'b0001 << exp_id);
            end
            tick();
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_withdrawn();
        bus.req = 4'b0010;
        bus.data_in[1*16 +: 16] = 16'h00FF;
        tick();
        total++;
        if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_grant id=%0d busy=%b want 1/1",
                     bus.grant_id, bus.busy);
        end
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.reg_out !== 16'h00FF || bus.ack !== 4'b0010) begin
            bad++;
            $display("FAIL wd_ack reg=%h ack=%b want 00ff/0010",
                     bus.reg_out, bus.ack);
        end
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b0) begin
            bad++;
            $display("FAIL wd_done busy=%b ack=%b want 0/0000",
                     bus.busy, bus.ack);
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b1000;
        bus.data_in[3*16 +: 16] = 16'h1234;
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd3) begin
            bad++;
            $display("FAIL mid_write busy=%b id=%0d want 1/3",
                     bus.busy, bus.grant_id);
        end
        rst_n = 1'b0;
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.reg_out !== 16'h0 || bus.ack !== 4'b0 ||
            bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset reg=%h ack=%b busy=%b id=%0d want 0000/0000/0/0",
                     bus.reg_out, bus.ack, bus.busy, bus.grant_id);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_noack ack=%b busy=%b want 0000/0",
                     bus.ack, bus.busy);
        end
        bus.req = 4'b1111;
        tick();
        total++;
        if (bus.grant_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_ptr id=%0d want 0", bus.grant_id);
        end
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.data_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_withdrawn();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
